register_file: RTL and testbench
================================

Name: register_file

Overview:
- 32-entry x 32-bit general-purpose register file for the single-cycle datapath.
- Sits directly downstream of the 5-bit 2:1 destination-register mux; the mux output (rt or rd select) drives the write address.
- Two asynchronous read ports serve operand fetch; one synchronous write port handles writeback.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W = 32
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- we  input  1  write enable, sampled on rising clk
- waddr  input  ADDR_W  write address; driven by the 5-bit destination mux result
- wdata  input  DATA_W  writeback data
- raddr1  input  ADDR_W  read port 1 address (rs)
- raddr2  input  ADDR_W  read port 2 address (rt)
- rdata1  output  DATA_W  read port 1 data
- rdata2  output  DATA_W  read port 2 data
- wr_count  output  8  count of committed writes to nonzero registers, saturating

Interface note: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst_n = 0, any time, independent of clk):
  - All 32 entries clear to 0 immediately.
  - wr_count clears to 0.
  - rdata1 and rdata2 therefore read 0.
  - Reset asserted mid-cycle discards any pending write. A write is not committed on an edge where rst_n = 0.
- Write:
  - On rising clk with rst_n = 1, we = 1, and waddr != 0: mem[waddr] <= wdata, and wr_count increments by 1.
  - wr_count saturates at 255; no wrap.
  - A write with waddr = 0 is silently dropped: no storage change, no count increment.
  - we = 0: no state change.
- Read:
  - Combinational from raddr; zero latency from address change to rdata.
  - raddrN = 0 always returns 0, regardless of we, waddr, or BYPASS.
- Bypass:
  - BYPASS = 1 and we = 1 and waddr == raddrN and waddr != 0: rdataN = wdata in the same cycle, before the edge.
  - Both read ports are bypassed independently. Both may hit the same write simultaneously.
  - BYPASS = 0: rdataN shows the old value until after the edge, then the new value.
- Simultaneous read/write of different addresses: no interaction.
- Back-to-back writes to the same address: the last edge wins; every committed write counts.
- Width rules:
  - wdata is stored unmodified; no sign extension.
  - Addresses are full 5-bit, with no aliasing.
- No X propagation after reset: every entry is defined.

Test Plan:
- Reset: after writing 0xDEADBEEF to r5, assert rst_n = 0 between edges -> rdata1 (raddr1 = 5) reads 0x00000000 immediately; wr_count = 0.
- Write/read: we = 1, waddr = 5'b10011 (r19), wdata = 0x12345678, edge; then raddr1 = 19, raddr2 = 19 -> both read 0x12345678; wr_count = 1.
- Zero register: we = 1, waddr = 0, wdata = 0xFFFFFFFF, edge; raddr1 = 0 -> rdata1 = 0; wr_count unchanged.
- Bypass: BYPASS = 1; r31 = 0x00000001; drive we = 1, waddr = 5'b11111, wdata = 0xA5A5A5A5, raddr2 = 31 before the edge -> rdata2 = 0xA5A5A5A5 pre-edge. With BYPASS = 0 -> rdata2 = 0x00000001 pre-edge, 0xA5A5A5A5 post-edge.
- Dest-mux integration: the mux drives waddr; op = 0 selects 5'b10011, op = 1 selects 5'b11111; write 0x11 then 0x22 on consecutive edges -> r19 = 0x11, r31 = 0x22, wr_count = 2.
- Saturation: 300 consecutive writes to r1 -> wr_count = 255; r1 holds the last wdata.

Source files
------------

// File: rtl/register_file.sv
// ============================================================================
//  register_file : 32 x 32 general-purpose register file, r0 hardwired to zero
//                  two async read ports, one sync write port, optional bypass
//  Revision      : 1.0  initial release
// ============================================================================
`default_nettype none

module register_file #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter bit BYPASS = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2,
   output logic [7:0]        wr_count
);

   localparam int        C_DEPTH   = 2 ** ADDR_W;
   localparam logic [7:0] C_CNT_MAX = 8'hFF;

   logic [DATA_W-1:0] mem_q [C_DEPTH];
   logic [7:0]        wr_count_q;
   logic [7:0]        wr_count_d;
   logic              w_commit;
   logic              w_hit1;
   logic              w_hit2;

   // Writes to r0 are dropped entirely, including the count and any forwarding.
   assign w_commit = rst_n && we && (waddr != '0);

   always_comb begin
      wr_count_d = wr_count_q;
      if (w_commit && (wr_count_q != C_CNT_MAX)) begin
         wr_count_d = wr_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < C_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_count_q <= '0;
      end else begin
         if (w_commit) begin
            mem_q[waddr] <= wdata;
         end
         wr_count_q <= wr_count_d;
      end
   end

   generate
      if (BYPASS) begin : g_bypass
         assign w_hit1 = w_commit && (waddr == raddr1);
         assign w_hit2 = w_commit && (waddr == raddr2);
      end else begin : g_no_bypass
         assign w_hit1 = 1'b0;
         assign w_hit2 = 1'b0;
      end
   endgenerate

   always_comb begin
      rdata1 = mem_q[raddr1];
      if (raddr1 == '0) begin
         rdata1 = '0;
      end else if (w_hit1) begin
         rdata1 = wdata;
      end
   end

   always_comb begin
      rdata2 = mem_q[raddr2];
      if (raddr2 == '0) begin
         rdata2 = '0;
      end else if (w_hit2) begin
         rdata2 = wdata;
      end
   end

   assign wr_count = wr_count_q;

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// ============================================================================
//  tb_register_file : scoreboard bench for register_file, bypass and no-bypass
//  Revision         : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_register_file;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  raddr1;
   logic [4:0]  raddr2;
   logic [31:0] rdata1, rdata2, nb_rdata1, nb_rdata2;
   logic [7:0]  wr_count, nb_wr_count;
   logic        op;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int          kind;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t sb[$];
   event sample_ev;

   always #5 clk = ~clk;

   register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .raddr2(raddr2),
      .rdata1(rdata1), .rdata2(rdata2), .wr_count(wr_count)
   );

   register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nb (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .raddr2(raddr2),
      .rdata1(nb_rdata1), .rdata2(nb_rdata2), .wr_count(nb_wr_count)
   );

   // Monitor: drains every queued expectation when a sample point is signalled.
   always @(sample_ev) begin
      exp_t        e;
      logic [31:0] act;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.kind)
            0:       act = rdata1;
            1:       act = rdata2;
            2:       act = {24'd0, wr_count};
            3:       act = nb_rdata1;
            4:       act = nb_rdata2;
            default: act = {24'd0, nb_wr_count};
         endcase
         total++;
         if (act !== e.exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
         end
      end
   end

   task automatic expect_val(input int k, input logic [31:0] v, input string n);
      sb.push_back('{k, v, n});
   endtask

   task automatic check();
      #1;
      ->sample_ev;
      #1;
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL monitor_drain: got %0d pending expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
      raddr1 = 5'd5; raddr2 = 5'd0; op = 1'b0;
      #1;
      expect_val(0, 32'h0, "reset_rdata1");
      expect_val(1, 32'h0, "reset_rdata2");
      expect_val(2, 32'h0, "reset_count");
      check();
      rst_n = 1'b1;

      // Write r5, then async reset between edges clears it immediately
      tick();
      we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
      tick();
      we = 1'b0;
      expect_val(0, 32'hDEADBEEF, "r5_written");
      expect_val(2, 32'd1, "count_after_r5");
      check();
      rst_n = 1'b0;
      expect_val(0, 32'h0, "r5_after_async_reset");
      expect_val(2, 32'h0, "count_after_async_reset");
      check();

      // A write presented across an edge while in reset is never committed
      we = 1'b1; waddr = 5'd7; wdata = 32'h00000055; raddr2 = 5'd7;
      expect_val(1, 32'h0, "no_bypass_in_reset");
      check();
      tick();
      expect_val(1, 32'h0, "r7_held_in_reset");
      expect_val(2, 32'h0, "count_held_in_reset");
      check();
      we = 1'b0;
      rst_n = 1'b1;
      expect_val(1, 32'h0, "r7_after_release");
      check();

      // Write / read r19 on both ports
      tick();
      we = 1'b1; waddr = 5'b10011; wdata = 32'h12345678;
      tick();
      we = 1'b0; raddr1 = 5'd19; raddr2 = 5'd19;
      expect_val(0, 32'h12345678, "r19_port1");
      expect_val(1, 32'h12345678, "r19_port2");
      expect_val(2, 32'd1, "count_after_r19");
      check();

      // r0 write is dropped, even pre-edge with bypass
      we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0;
      expect_val(0, 32'h0, "r0_pre_edge");
      check();
      tick();
      we = 1'b0;
      expect_val(0, 32'h0, "r0_post_edge");
      expect_val(2, 32'd1, "count_r0_unchanged");
      check();

      // Bypass vs no-bypass on r31
      we = 1'b1; waddr = 5'd31; wdata = 32'h00000001;
      tick();
      wdata = 32'hA5A5A5A5; raddr1 = 5'd19; raddr2 = 5'd31;
      expect_val(1, 32'hA5A5A5A5, "bypass_rdata2_pre");
      expect_val(4, 32'h00000001, "nobypass_rdata2_pre");
      expect_val(0, 32'h12345678, "other_addr_unaffected");
      check();
      tick();
      we = 1'b0;
      expect_val(4, 32'hA5A5A5A5, "nobypass_rdata2_post");
      expect_val(1, 32'hA5A5A5A5, "bypass_rdata2_post");
      expect_val(2, 32'd3, "count_after_bypass");
      check();

      // Both ports hitting the same write
      we = 1'b1; wdata = 32'h0F0F0F0F; raddr1 = 5'd31; raddr2 = 5'd31;
      expect_val(0, 32'h0F0F0F0F, "dual_bypass_port1");
      expect_val(1, 32'h0F0F0F0F, "dual_bypass_port2");
      expect_val(3, 32'hA5A5A5A5, "dual_nobypass_port1");
      check();
      tick();
      we = 1'b0;
      expect_val(2, 32'd4, "count_after_dual");
      check();

      // Fresh reset, then destination-mux driven writes
      rst_n = 1'b0;
      expect_val(2, 32'd0, "count_reset_pulse");
      check();
      rst_n = 1'b1;
      tick();
      we = 1'b1; op = 1'b0; waddr = op ? 5'b11111 : 5'b10011; wdata = 32'h11;
      tick();
      op = 1'b1; waddr = op ? 5'b11111 : 5'b10011; wdata = 32'h22;
      tick();
      we = 1'b0; raddr1 = 5'd19; raddr2 = 5'd31;
      expect_val(0, 32'h11, "mux_r19");
      expect_val(1, 32'h22, "mux_r31");
      expect_val(2, 32'd2, "mux_count");
      expect_val(5, 32'd2, "mux_count_nobypass");
      check();

      // Saturation: 300 writes to r1
      we = 1'b1; waddr = 5'd1; raddr1 = 5'd1; raddr2 = 5'd19;
      for (int i = 0; i < 300; i++) begin
         wdata = 32'(i);
         tick();
         if (i == 199) begin
            expect_val(2, 32'd202, "count_mid_run");
            check();
         end
      end
      we = 1'b0;
      expect_val(0, 32'h0000012B, "r1_last_write");
      expect_val(2, 32'd255, "count_saturated");
      expect_val(1, 32'h11, "r19_untouched");
      check();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
